// File: rtl/controller_pio_edge_in.sv
// Edge-capturing parallel input port with a small memory-mapped register set.
// External inputs are synchronised, per-bit rise/fall edges are detected and
// latched into a sticky capture register, and a second capture on a bit that
// is still pending is flagged in an overflow register. A masked OR of the
// capture bits drives a level interrupt.
//
// Register map (word addresses):
//   0 data          RO   synchronised input value
//   1 rise_en       RW   per-bit rising-edge enable
//   2 fall_en       RW   per-bit falling-edge enable
//   3 irq_mask      RW   per-bit interrupt enable
//   4 edge_capture  CLR  sticky edge flags
//   5 overflow      CLR  sticky "edge while already captured" flags
//   6-7             --   read as zero, writes ignored
module controller_pio_edge_in #(
    parameter int WIDTH        = 25,
    parameter int SYNC_STAGES  = 2,
    parameter int BIT_CLEARING = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd2;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
    localparam logic [2:0] ADDR_CAPTURE  = 3'd4;
    localparam logic [2:0] ADDR_OVERFLOW = 3'd5;

    // Place a WIDTH-bit register value into the low bits of a 32-bit word.
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] val);
        logic [31:0] word;
        word             = '0;
        word[WIDTH-1:0]  = val;
        return word;
    endfunction

    // Bits to clear for a clear-on-write register: either the bits written
    // as 1, or every bit when the block is built for whole-register clears.
    function automatic logic [WIDTH-1:0] clear_mask(input logic             hit,
                                                    input logic [WIDTH-1:0] wdata);
        logic [WIDTH-1:0] mask;
        mask = '0;
        if (hit) begin
            mask = (BIT_CLEARING != 0) ? wdata : '1;
        end
        return mask;
    endfunction

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] prev_q;

    logic [WIDTH-1:0] rise_en_q,  rise_en_d;
    logic [WIDTH-1:0] fall_en_q,  fall_en_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] capture_q,  capture_d;
    logic [WIDTH-1:0] overflow_q, overflow_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_capture;
    logic [WIDTH-1:0] clr_overflow;

    // Only the low WIDTH bits of writedata are register content; the rest
    // are folded into a dummy net so they are intentionally consumed.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign wr_en    = chipselect & ~write_n;
    assign wdata    = writedata[WIDTH-1:0];
    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: stage 0 samples the raw pins, each later stage
    // re-registers the previous one to settle metastability.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // One-clock delayed copy of the synchronised value for edge detection.
    // Reset to 0 so a pin held high through reset looks like a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_out;
        end
    end

    // Per-bit edge detection qualified by the currently programmed enables.
    always_comb begin
        edge_det = (rise_en_q &  sync_out & ~prev_q)
                 | (fall_en_q & ~sync_out &  prev_q);
    end

    // Next-state for configuration registers: load on a write to their slot.
    always_comb begin
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        irq_mask_d = irq_mask_q;
        if (wr_en) begin
            case (address)
                ADDR_RISE_EN:  rise_en_d  = wdata;
                ADDR_FALL_EN:  fall_en_d  = wdata;
                ADDR_IRQ_MASK: irq_mask_d = wdata;
                default: ;
            endcase
        end
    end

    // Next-state for the sticky capture/overflow registers. A new edge always
    // wins over a clear on the same bit; an overflow is only raised when the
    // bit was already pending and is not being cleared in this same cycle.
    always_comb begin
        clr_capture  = clear_mask(wr_en && (address == ADDR_CAPTURE),  wdata);
        clr_overflow = clear_mask(wr_en && (address == ADDR_OVERFLOW), wdata);
        capture_d    = (capture_q  & ~clr_capture)  | edge_det;
        overflow_d   = (overflow_q & ~clr_overflow)
                     | (edge_det & capture_q & ~clr_capture);
    end

    // Read mux: selected register, zero-extended; unmapped slots return 0.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d = zext(sync_out);
            ADDR_RISE_EN:  readdata_d = zext(rise_en_q);
            ADDR_FALL_EN:  readdata_d = zext(fall_en_q);
            ADDR_IRQ_MASK: readdata_d = zext(irq_mask_q);
            ADDR_CAPTURE:  readdata_d = zext(capture_q);
            ADDR_OVERFLOW: readdata_d = zext(overflow_q);
            default:       readdata_d = '0;
        endcase
    end

    // Register state; everything returns to zero on reset, discarding any
    // pending captures, overflows and configuration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_mask_q <= '0;
            capture_q  <= '0;
            overflow_q <= '0;
            readdata_q <= '0;
        end else begin
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            irq_mask_q <= irq_mask_d;
            capture_q  <= capture_d;
            overflow_q <= overflow_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    // Level interrupt straight from registers so a mask change acts at once.
    assign irq      = |(capture_q & irq_mask_q);

endmodule

// File: tb/tb_controller_pio_edge_in.sv
// Bench for controller_pio_edge_in: instance A uses bit clearing, instance B
// uses whole-register clearing. Reads are queued with their expected value
// and checked by a monitor when the registered read data appears.
module tb_controller_pio_edge_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        cs_a, cs_b;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port_a, in_port_b;
    logic [31:0] readdata_a, readdata_b;
    logic        irq_a, irq_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          sel_b;
        logic [2:0]  addr;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    controller_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .BIT_CLEARING(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_a),
        .readdata(readdata_a), .irq(irq_a)
    );

    controller_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .BIT_CLEARING(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_b),
        .readdata(readdata_b), .irq(irq_b)
    );

    // Scoreboard monitor: one clock after a read is issued, compare.
    always @(posedge clk) begin
        sb_t e;
        logic [31:0] got;
        #1;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = e.sel_b ? readdata_b : readdata_a;
            n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL read_%s_addr%0d got=%08h exp=%08h", e.sel_b ? "B" : "A",
                         e.addr, got, e.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input bit sel_b, input logic [2:0] a, input logic [31:0] d);
        cs_a      = ~sel_b;
        cs_b      = sel_b;
        write_n   = 1'b0;
        address   = a;
        writedata = d;
        step();
        cs_a    = 1'b0;
        cs_b    = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input bit sel_b, input logic [2:0] a, input logic [31:0] exp);
        sb_t e;
        address = a;
        e.sel_b = sel_b;
        e.addr  = a;
        e.exp   = exp;
        sb.push_back(e);
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_n(2);
        n_checks++;
        if (readdata_a !== 32'h0 || irq_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got rd=%08h irq=%b exp rd=0 irq=0", readdata_a, irq_a);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) rd(0, 3'(a), 32'h0);
    endtask

    task automatic test_config();
        wr(0, 1, 32'hA5);
        rd(0, 1, 32'hA5);
        wr(0, 2, 32'h3C);
        rd(0, 2, 32'h3C);
        wr(0, 3, 32'hFFFF_FF5A);
        rd(0, 3, 32'h5A);
        // write with chipselect low, then with write_n high: both ignored
        cs_a = 1'b0; write_n = 1'b0; address = 1; writedata = 32'h11;
        step();
        cs_a = 1'b1; write_n = 1'b1;
        step();
        cs_a = 1'b0;
        rd(0, 1, 32'hA5);
        wr(0, 1, 0);
        wr(0, 2, 0);
        wr(0, 3, 0);
    endtask

    task automatic test_rise();
        logic [2:0] exp_irq;
        wr(0, 1, 32'h01);
        wr(0, 3, 32'h01);
        in_port_a = 8'h01;
        exp_irq = 3'b100;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (irq_a !== exp_irq[i]) begin
                n_fail++;
                $display("FAIL rise_latency_edge%0d irq=%b exp=%b", i, irq_a, exp_irq[i]);
            end
        end
        rd(0, 4, 32'h01);
        rd(0, 0, 32'h01);
        wr(0, 4, 32'h01);
        n_checks++;
        if (irq_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_clear_irq irq=%b exp=0", irq_a);
        end
        rd(0, 4, 32'h0);
    endtask

    task automatic test_fall();
        wr(0, 2, 32'h80);
        wr(0, 3, 32'h80);
        in_port_a = 8'h81;
        wait_n(3);
        n_checks++;
        if (irq_a !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_ignores_rise irq=%b exp=0", irq_a);
        end
        rd(0, 4, 32'h0);
        in_port_a = 8'h01;
        wait_n(3);
        n_checks++;
        if (irq_a !== 1'b1) begin
            n_fail++;
            $display("FAIL fall_irq irq=%b exp=1", irq_a);
        end
        rd(0, 4, 32'h80);
        wr(0, 4, 32'h80);
        n_checks++;
        if (irq_a !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_clear_irq irq=%b exp=0", irq_a);
        end
        rd(0, 4, 32'h0);
    endtask

    task automatic test_overflow();
        wr(0, 2, 0);
        wr(0, 3, 0);
        wr(0, 1, 32'h03);
        in_port_a = 8'h00;
        wait_n(3);
        in_port_a = 8'h03;
        wait_n(3);
        rd(0, 4, 32'h03);
        wr(0, 4, 32'h01);
        rd(0, 4, 32'h02);
        rd(0, 5, 32'h00);
        in_port_a = 8'h01;
        wait_n(3);
        in_port_a = 8'h03;
        wait_n(3);
        rd(0, 5, 32'h02);
        rd(0, 4, 32'h02);
        wr(0, 5, 32'h02);
        rd(0, 5, 32'h00);
        wr(0, 4, 32'hFF);
        rd(0, 4, 32'h00);
    endtask

    task automatic test_simultaneous_clear();
        wr(0, 1, 32'h04);
        in_port_a = 8'h07;
        wait_n(3);
        rd(0, 4, 32'h04);
        in_port_a = 8'h03;
        wait_n(3);
        in_port_a = 8'h07;
        wait_n(2);
        wr(0, 4, 32'h04);     // lands on the capture edge of the new rise
        rd(0, 4, 32'h04);
        rd(0, 5, 32'h00);
        wr(0, 4, 32'hFF);
        rd(0, 4, 32'h00);
    endtask

    task automatic test_both_edges();
        wr(0, 1, 32'h08);
        wr(0, 2, 32'h08);
        in_port_a = 8'h0F;
        wait_n(3);
        rd(0, 4, 32'h08);
        wr(0, 4, 32'h08);
        in_port_a = 8'h07;
        wait_n(3);
        rd(0, 4, 32'h08);
        // disabling detection keeps what was already captured
        wr(0, 1, 0);
        wr(0, 2, 0);
        rd(0, 4, 32'h08);
        rd(0, 5, 32'h00);
        wr(0, 4, 32'h08);
    endtask

    task automatic test_unmapped();
        wr(0, 1, 32'h33);
        rd(0, 6, 32'h0);
        rd(0, 7, 32'h0);
        wr(0, 0, 32'hFF);
        wr(0, 6, 32'hFF);
        wr(0, 7, 32'hFF);
        rd(0, 1, 32'h33);
        rd(0, 2, 32'h0);
        rd(0, 3, 32'h0);
        rd(0, 4, 32'h0);
        rd(0, 5, 32'h0);
        rd(0, 0, 32'h07);
        wr(0, 1, 0);
    endtask

    task automatic test_reset_midop();
        wr(0, 1, 32'hFF);
        wr(0, 3, 32'hFF);
        in_port_a = 8'h00;
        wait_n(3);
        in_port_a = 8'hFF;
        wait_n(3);
        n_checks++;
        if (irq_a !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_irq_before irq=%b exp=1", irq_a);
        end
        rd(0, 4, 32'hFF);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (irq_a !== 1'b0 || readdata_a !== 32'h0) begin
            n_fail++;
            $display("FAIL midop_async_reset irq=%b rd=%08h exp irq=0 rd=0", irq_a, readdata_a);
        end
        wait_n(2);
        reset_n = 1'b1;
        for (int a = 1; a < 6; a++) rd(0, 3'(a), 32'h0);
        n_checks++;
        if (irq_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_no_residual_irq irq=%b exp=0", irq_a);
        end
    endtask

    task automatic test_reset_release_edge();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;       // in_port_a still held at 0xFF
        wr(0, 1, 32'h01);
        wr(0, 3, 32'h01);
        n_checks++;
        if (irq_a !== 1'b0) begin
            n_fail++;
            $display("FAIL release_edge_early irq=%b exp=0", irq_a);
        end
        step();
        n_checks++;
        if (irq_a !== 1'b1) begin
            n_fail++;
            $display("FAIL release_edge_seen irq=%b exp=1", irq_a);
        end
        rd(0, 4, 32'h01);
        rd(0, 5, 32'h00);
    endtask

    task automatic test_bitclr0();
        wr(1, 1, 32'hFF);
        in_port_b = 8'h5A;
        wait_n(3);
        rd(1, 4, 32'h5A);
        in_port_b = 8'h00;
        wait_n(3);
        in_port_b = 8'h5A;
        wait_n(3);
        rd(1, 5, 32'h5A);
        wr(1, 5, 32'h00);
        rd(1, 5, 32'h00);
        rd(1, 4, 32'h5A);
        wr(1, 4, 32'h00);
        rd(1, 4, 32'h00);
        rd(1, 6, 32'h00);
        wr(1, 0, 32'hFF);
        rd(1, 1, 32'hFF);
        rd(1, 4, 32'h00);
        rd(1, 0, 32'h5A);
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = '0;
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        write_n   = 1'b1;
        writedata = '0;
        in_port_a = '0;
        in_port_b = '0;
        test_reset();
        test_config();
        test_rise();
        test_fall();
        test_overflow();
        test_simultaneous_clear();
        test_both_edges();
        test_unmapped();
        test_reset_midop();
        test_reset_release_edge();
        test_bitclr0();
        wait_n(2);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain pending=%0d exp=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controller_pio_edge_in.md
CONTROLLER_PIO_EDGE_IN -- requirements
Module: controller_pio_edge_in

Interface
REQ-001 SHALL have parameter WIDTH, default 25, input port width (legal range 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops per bit (legal range 2..4).
REQ-003 SHALL have parameter BIT_CLEARING, default 1: 1 = write-1-to-clear on capture registers; 0 = any write clears all bits.
REQ-004 SHALL have port clk, input, 1, clock; all flops rising-edge.
REQ-005 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port address, input, 3, register select.
REQ-007 SHALL have port chipselect, input, 1, slave select.
REQ-008 SHALL have port write_n, input, 1, active-low write strobe.
REQ-009 SHALL have port writedata, input, 32, write data.
REQ-010 SHALL have port in_port, input, WIDTH, asynchronous external inputs.
REQ-011 SHALL have port readdata, output, 32, registered read data.
REQ-012 SHALL have port irq, output, 1, level interrupt.

Function
REQ-013 Write strobe SHALL be chipselect=1 and write_n=0; no other condition writes.
REQ-014 Register map SHALL be: 0 data (RO), 1 rise_en (RW), 2 fall_en (RW), 3 irq_mask (RW), 4 edge_capture (clear-on-write), 5 overflow (clear-on-write), 6-7 unmapped.
REQ-015 Each in_port bit SHALL pass through SYNC_STAGES flops; sync_out is the last stage; prev is sync_out delayed one clock.
REQ-016 Per-bit edge SHALL be (rise_en & sync_out & ~prev) | (fall_en & ~sync_out & prev); with both enables set, either transition counts.
REQ-017 An in_port transition sampled at clock edge N SHALL set edge_capture at clock edge N+SYNC_STAGES.
REQ-018 edge_capture bit SHALL set on edge and hold until cleared; repeat edges leave it at 1.
REQ-019 overflow bit SHALL set when an edge occurs on a bit whose edge_capture is already 1 and is not being cleared that same clock; holds until cleared.
REQ-020 Clear with BIT_CLEARING=1: writing address 4 or 5 SHALL clear exactly the bits where writedata=1; bits with writedata=0 unchanged.
REQ-021 Clear with BIT_CLEARING=0: any write to address 4 or 5 SHALL clear all bits of that register regardless of writedata.
REQ-022 Simultaneous clear and new edge on the same bit SHALL leave edge_capture=1 (edge wins) and SHALL NOT set overflow.
REQ-023 Writes to addresses 1-3 SHALL load writedata[WIDTH-1:0]; writes to 0, 6, 7 SHALL be ignored.
REQ-024 readdata SHALL update every clock (independent of chipselect) with the register selected by address, zero-extended; data returns sync_out; unmapped addresses read 0; latency exactly one clock.
REQ-025 Config registers (1-3) SHALL read back as written; bits WIDTH..31 SHALL read 0.
REQ-026 irq SHALL be the OR of (edge_capture & irq_mask), driven combinationally from registers; changing irq_mask SHALL affect irq in the same cycle.
REQ-027 Changing rise_en/fall_en SHALL affect only future edges; existing capture bits unchanged.

Reset
REQ-028 On reset_n=0, all synchroniser flops, prev, rise_en, fall_en, irq_mask, edge_capture, overflow and readdata SHALL go to 0 asynchronously; irq SHALL be 0.
REQ-029 An input held high through reset release SHALL be seen as a rising edge SYNC_STAGES clocks after release (if rise_en set by then); this is required behaviour.
REQ-030 Reset asserted mid-operation SHALL discard pending captures, overflows and configuration with no residual irq.

Verification (WIDTH=8, SYNC_STAGES=2, BIT_CLEARING=1 unless stated)
REQ-031 rise_en=0x01, in_port bit0 0->1 sampled at edge N -> edge_capture=0x01 at edge N+2; read addr4 returns 0x00000001 one clock after address presented.
REQ-032 fall_en=0x80, irq_mask=0x80, in_port bit7 1->0 -> edge_capture=0x80, irq=1; write addr4 data 0x80 -> edge_capture=0x00, irq=0 next clock.
REQ-033 rise_en=0x03, capture=0x03, write addr4 data 0x01 -> capture=0x02; second rising edge on bit1 -> overflow=0x02.
REQ-034 Write addr4 data 0x04 in the same clock as rising edge on bit2 -> edge_capture bit2=1, overflow bit2=0.
REQ-035 BIT_CLEARING=0, capture=0x5A, write addr4 data 0x00 -> capture=0x00; read addr6 -> 0x00000000; write addr0 -> no register change.
REQ-036 Assert reset_n=0 with capture=0xFF, irq=1 -> all registers 0, irq=0 immediately, before the next clock edge.
